// File: rtl/rr_bus_arbiter4.sv
// rr_bus_arbiter4: four requesters share one registered WIDTH-bit output stage through a round-robin arbiter.
// Define RR_ARB_FIXED_PRIO_EN to replace round-robin with fixed priority (requester 0 highest).
module rr_bus_arbiter4 #(
    parameter int unsigned WIDTH    = 32,
    parameter logic [1:0]  PTR_INIT = 2'd3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       req_valid,
    input  logic [WIDTH-1:0] req_data0,
    input  logic [WIDTH-1:0] req_data1,
    input  logic [WIDTH-1:0] req_data2,
    input  logic [WIDTH-1:0] req_data3,
    output logic [3:0]       req_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       grant_sel,
    output logic             busy
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t           state_r;
    state_t           state_s;
    logic [1:0]       win_s;
    logic             accept_s;
    logic             capture_s;
    logic [WIDTH-1:0] mux_data_s;

`ifdef RR_ARB_FIXED_PRIO_EN
    function automatic logic [1:0] pick_winner(input logic [3:0] valid);
        logic [1:0] res;
        res = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (valid[i]) begin
                res = 2'(i);
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Winner selection: lowest-index valid requester
    always_comb begin
        win_s = pick_winner(req_valid);
    end
`else
    logic [1:0] last_ptr_r;

    function automatic logic [1:0] pick_winner(input logic [3:0] valid, input logic [1:0] ptr);
        logic [1:0] res;
        logic [1:0] idx;
        res = ptr;
        // Scan farthest-first so the nearest valid requester after ptr is the last to overwrite
        for (int k = 4; k >= 1; k--) begin
            idx = ptr + 2'(k);
            if (valid[idx]) begin
                res = idx;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Winner selection: first valid requester after the last grant
    always_comb begin
        win_s = pick_winner(req_valid, last_ptr_r);
    end

    // Last-grant pointer; rotates only when a word is captured
    always_ff @(posedge clk) begin
        if (reset) begin
            last_ptr_r <= PTR_INIT;
        end else if (capture_s) begin
            last_ptr_r <= win_s;
        end else begin
            last_ptr_r <= last_ptr_r;
        end
    end
`endif

    // Accept and capture qualifiers; nothing is granted while reset is held
    always_comb begin
        accept_s  = (state_r == EMPTY) || out_ready;
        capture_s = accept_s && (req_valid != 4'b0000) && !reset;
    end

    // 4:1 data mux driven by the winner
    always_comb begin
        case (win_s)
            2'd0:    mux_data_s = req_data0;
            2'd1:    mux_data_s = req_data1;
            2'd2:    mux_data_s = req_data2;
            2'd3:    mux_data_s = req_data3;
            default: mux_data_s = req_data0;
        endcase
    end

    // Next-state and one-hot grant
    always_comb begin
        state_s   = state_r;
        req_ready = 4'b0000;
        if (capture_s) begin
            req_ready = 4'b0001 << win_s;
        end else begin
            req_ready = 4'b0000;
        end
        case (state_r)
            EMPTY: begin
                if (capture_s) begin
                    state_s = FULL;
                end else begin
                    state_s = EMPTY;
                end
            end
            FULL: begin
                if (capture_s) begin
                    state_s = FULL;
                end else if (out_ready) begin
                    state_s = EMPTY;
                end else begin
                    state_s = FULL;
                end
            end
            default: state_s = EMPTY;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= EMPTY;
        end else begin
            state_r <= state_s;
        end
    end

    // Output stage: data and source select load together on capture, otherwise hold
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data  <= {WIDTH{1'b0}};
            grant_sel <= 2'd0;
        end else if (capture_s) begin
            out_data  <= mux_data_s;
            grant_sel <= win_s;
        end else begin
            out_data  <= out_data;
            grant_sel <= grant_sel;
        end
    end

    assign out_valid = (state_r == FULL);
    assign busy      = (state_r == FULL) && !out_ready;

endmodule

// File: tb/tb_rr_bus_arbiter4.sv
// Directed bench for rr_bus_arbiter4: a reference arbiter model plus a scoreboard of captured words,
// checked every cycle, with explicit test-plan values checked on top.
module tb_rr_bus_arbiter4;

    localparam logic [1:0] PINIT = 2'd3;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] d0, d1, d2, d3;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic [1:0]  grant_sel;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [33:0] sb[$];
    logic        m_valid;
    logic [1:0]  m_ptr;
    logic [1:0]  m_sel;
    logic [31:0] m_data;
    logic [3:0]  seen_rdy;
    logic        seen_busy;

    rr_bus_arbiter4 #(.WIDTH(32), .PTR_INIT(PINIT)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid),
        .req_data0(d0), .req_data1(d1), .req_data2(d2), .req_data3(d3),
        .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .grant_sel(grant_sel), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] model_pick(input logic [3:0] v, input logic [1:0] ptr);
`ifdef RR_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 4; i++) begin
            if (v[i]) return 2'(i);
        end
`else
        for (int k = 1; k <= 4; k++) begin
            int idx;
            idx = (int'(ptr) + k) % 4;
            if (v[idx]) return 2'(idx);
        end
`endif
        return 2'd0;
    endfunction

    function automatic logic [31:0] data_of(input logic [1:0] w);
        case (w)
            2'd0:    return d0;
            2'd1:    return d1;
            2'd2:    return d2;
            default: return d3;
        endcase
    endfunction

    // One clock: check combinational grant at negedge, registered outputs after the edge
    task automatic cycle(input string tag);
        logic        acc;
        logic        cap;
        logic [1:0]  w;
        logic [3:0]  er;
        logic [33:0] e;
        @(negedge clk);
        acc = !m_valid || out_ready;
        cap = acc && (req_valid != 4'b0000) && !reset;
        w   = model_pick(req_valid, m_ptr);
        er  = cap ? (4'b0001 << w) : 4'b0000;
        seen_rdy  = req_ready;
        seen_busy = busy;
        chk($sformatf("%s.req_ready", tag), 64'(req_ready), 64'(er));
        chk($sformatf("%s.busy", tag), 64'(busy), 64'(m_valid && !out_ready));
        if (cap) sb.push_back({w, data_of(w)});
        @(posedge clk);
        #1;
        if (reset) begin
            m_valid = 1'b0; m_data = 32'h0; m_sel = 2'd0; m_ptr = PINIT;
        end else if (cap) begin
            e = sb.pop_front();
            m_valid = 1'b1; m_sel = e[33:32]; m_data = e[31:0]; m_ptr = w;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        chk($sformatf("%s.out_valid", tag), 64'(out_valid), 64'(m_valid));
        chk($sformatf("%s.out_data", tag), 64'(out_data), 64'(m_data));
        chk($sformatf("%s.grant_sel", tag), 64'(grant_sel), 64'(m_sel));
    endtask

    initial begin
        logic [1:0] exp_g [5];
        exp_g = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        reset = 1'b1; req_valid = 4'b0000; out_ready = 1'b0;
        d0 = 32'h0; d1 = 32'h0; d2 = 32'h0; d3 = 32'h0;
        m_valid = 1'b0; m_data = 32'h0; m_sel = 2'd0; m_ptr = PINIT;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        cycle("reset_idle");
        chk("reset.out_valid", 64'(out_valid), 64'd0);
        chk("reset.req_ready", 64'(seen_rdy), 64'd0);

        req_valid = 4'b0100; d2 = 32'hDEAD_BEEF; out_ready = 1'b1;
        cycle("single");
        chk("single.ready_onehot", 64'(seen_rdy), 64'b0100);
        chk("single.data", 64'(out_data), 64'h0000_0000_DEAD_BEEF);
        chk("single.sel", 64'(grant_sel), 64'd2);
        req_valid = 4'b0000;
        cycle("single_drain");

        reset = 1'b1;
        cycle("rst2");
        reset = 1'b0;
        d0 = 32'h1000_0000; d1 = 32'h1000_0001; d2 = 32'h1000_0002; d3 = 32'h1000_0003;
        req_valid = 4'b1111; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle("rr");
            chk("rr.valid_no_bubble", 64'(out_valid), 64'd1);
`ifndef RR_ARB_FIXED_PRIO_EN
            chk("rr.grant_order", 64'(grant_sel), 64'(exp_g[i]));
            chk("rr.data_order", 64'(out_data), 64'h1000_0000 + 64'(exp_g[i]));
`endif
        end

        req_valid = 4'b0010; d1 = 32'h0000_00AA; out_ready = 1'b1;
        cycle("bp_load");
        chk("bp_load.data", 64'(out_data), 64'h0000_00AA);
        req_valid = 4'b0011; d0 = 32'h0000_0011; d1 = 32'h0000_00BB; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle("bp_hold");
            chk("bp_hold.ready", 64'(seen_rdy), 64'd0);
            chk("bp_hold.busy", 64'(seen_busy), 64'd1);
            chk("bp_hold.data", 64'(out_data), 64'h0000_00AA);
        end
        out_ready = 1'b1;
        cycle("bp_release");
        chk("bp_release.ready", 64'(seen_rdy), 64'b0001);
        chk("bp_release.data", 64'(out_data), 64'h0000_0011);

        req_valid = 4'b0010;
        cycle("load1");
        chk("load1.sel", 64'(grant_sel), 64'd1);
        req_valid = 4'b0000;
        cycle("drain");
        chk("drain.valid", 64'(out_valid), 64'd0);
        chk("drain.sel_hold", 64'(grant_sel), 64'd1);
        chk("drain.data_hold", 64'(out_data), 64'h0000_00BB);
        cycle("idle_hold");

        req_valid = 4'b0100; d2 = 32'h0000_00CC; out_ready = 1'b0;
        cycle("mid_load");
        req_valid = 4'b0000; reset = 1'b1;
        cycle("mid_reset");
        chk("mid_reset.valid", 64'(out_valid), 64'd0);
        chk("mid_reset.data", 64'(out_data), 64'd0);
        reset = 1'b0; req_valid = 4'b1001; d0 = 32'h0000_0A00; d3 = 32'h0000_0A03; out_ready = 1'b1;
        cycle("after_reset");
        chk("after_reset.ready", 64'(seen_rdy), 64'b0001);
        chk("after_reset.sel", 64'(grant_sel), 64'd0);
        req_valid = 4'b1000;
        cycle("after_reset2");
        chk("after_reset2.sel", 64'(grant_sel), 64'd3);

`ifdef RR_ARB_FIXED_PRIO_EN
        req_valid = 4'b1010; d1 = 32'h0000_0B01; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle("fixed");
            chk("fixed.ready", 64'(seen_rdy), 64'b0010);
            chk("fixed.sel", 64'(grant_sel), 64'd1);
        end
`else
        req_valid = 4'b1010; d1 = 32'h0000_0B01; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle("alt");
            chk("alt.sel", 64'(grant_sel), (i % 2 == 0) ? 64'd1 : 64'd3);
        end
`endif
        req_valid = 4'b0000;
        cycle("final_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
